// File: rtl/i2s_tdm_tx_core_if.sv
// AXI-Stream sample channel feeding the I2S/TDM serializer.
// tdata carries the sample in bits [AUD_WIDTH+3:4]; tid carries the channel number.
interface i2s_tdm_tx_core_if #(
  parameter int TDATA_W = 32,
  parameter int TID_W   = 3
);
  logic [TDATA_W-1:0] tdata;
  logic [TID_W-1:0]   tid;
  logic               tvalid;
  logic               tready;

  modport master (output tdata, tid, tvalid, input tready);
  modport slave  (input tdata, tid, tvalid, output tready);
endinterface

// File: rtl/i2s_tdm_tx_core.sv
// Channel-tagged AXI-Stream samples -> sample FIFO -> I2S stereo or TDM serial link.
// Everything runs on aud_mclk; sclk is a divided, registered copy.
module i2s_tdm_tx_core #(
  parameter int AUD_WIDTH  = 24,
  parameter int SLOT_W     = 32,
  parameter int NUM_CH     = 2,
  parameter int MODE       = 0,
  parameter int SCLK_DIV   = 1,
  parameter int FIFO_DEPTH = 16,
  parameter int TDATA_W    = 32,
  parameter int TID_W      = 3
) (
  input  logic                        aud_mclk,
  input  logic                        aud_mrst_n,
  input  logic                        enable,
  i2s_tdm_tx_core_if.slave            s_axis_aud,
  output logic                        i2s_sclk_out,
  output logic                        i2s_lrclk_out,
  output logic                        i2s_sdata_out,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count,
  output logic                        underflow,
  output logic                        tid_err
);

  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int CNT_W = AW + 1;
  localparam int DIV_W = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;
  localparam int BIT_W = (SLOT_W > 1) ? $clog2(SLOT_W) : 1;
  localparam int SLT_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int PAD_W = SLOT_W - AUD_WIDTH;

  if (MODE == 0 && NUM_CH != 2) begin : g_bad_i2s_ch
    $error("i2s_tdm_tx_core: MODE 0 needs NUM_CH == 2");
  end
  if (MODE == 1 && (NUM_CH < 2 || NUM_CH > 8)) begin : g_bad_tdm_ch
    $error("i2s_tdm_tx_core: MODE 1 needs NUM_CH in 2..8");
  end
  if (MODE != 0 && MODE != 1) begin : g_bad_mode
    $error("i2s_tdm_tx_core: MODE must be 0 or 1");
  end
  if (AUD_WIDTH > SLOT_W || AUD_WIDTH + 4 > TDATA_W) begin : g_bad_width
    $error("i2s_tdm_tx_core: sample does not fit the slot or the stream word");
  end
  if (SCLK_DIV < 1 || FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_size
    $error("i2s_tdm_tx_core: SCLK_DIV >= 1 and power-of-2 FIFO_DEPTH >= 2 required");
  end
  if (NUM_CH > (1 << TID_W)) begin : g_bad_tid
    $error("i2s_tdm_tx_core: TID_W too narrow for NUM_CH");
  end

  typedef enum logic {IDLE, RUN} state_t;

  state_t               state;
  logic [AUD_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr, rd_ptr;
  logic [TID_W-1:0]     wr_ch;
  logic [DIV_W-1:0]     div_cnt;
  logic [BIT_W-1:0]     bit_cnt, next_bit;
  logic [SLT_W-1:0]     slot_cnt, next_slot;
  logic [SLOT_W-1:0]    shreg, load_word;
  logic                 muted, next_lr;
  logic                 accept, push, pop, have_frame;
  logic                 div_wrap, fall_tick, last_bit, last_slot, frame_end, frame_go;
  logic [TDATA_W-1:0]   unused_tdata;

  assign unused_tdata      = s_axis_aud.tdata;
  assign s_axis_aud.tready = (fifo_count != CNT_W'(FIFO_DEPTH));
  assign accept            = s_axis_aud.tvalid && s_axis_aud.tready;
  assign push              = accept && (s_axis_aud.tid == wr_ch);
  assign have_frame        = (fifo_count >= CNT_W'(NUM_CH));

  assign div_wrap  = (div_cnt == DIV_W'(SCLK_DIV - 1));
  assign fall_tick = (state == RUN) && div_wrap && i2s_sclk_out;
  assign last_bit  = (bit_cnt == BIT_W'(SLOT_W - 1));
  assign last_slot = (slot_cnt == SLT_W'(NUM_CH - 1));
  assign frame_end = fall_tick && last_bit && last_slot;
  assign frame_go  = enable && ((state == IDLE) || frame_end);

  // A frame either pops every slot or none: the decision is made once at frame start.
  assign pop       = (frame_go && have_frame) || (fall_tick && last_bit && !last_slot && !muted);
  assign load_word = pop ? (SLOT_W'(mem[rd_ptr]) << PAD_W) : '0;

  // NOTE: every variable assigned here gets a default first so no latch is inferred.
  always_comb begin
    next_bit  = bit_cnt + 1'b1;
    next_slot = slot_cnt;
    if (last_bit) begin
      next_bit  = '0;
      next_slot = last_slot ? '0 : slot_cnt + 1'b1;
    end
    next_lr = (MODE == 0) ? (next_slot != '0) : ((next_bit == '0) && (next_slot == '0));
  end

  // NOTE: sample storage has no reset; pointers and count alone define what is valid.
  always_ff @(posedge aud_mclk) begin
    if (push) mem[wr_ptr] <= s_axis_aud.tdata[AUD_WIDTH+3:4];
  end

  // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge aud_mclk) begin
    if (!aud_mrst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      wr_ch      <= '0;
      fifo_count <= '0;
      tid_err    <= 1'b0;
    end else begin
      tid_err    <= accept && !push;
      fifo_count <= fifo_count + CNT_W'(push) - CNT_W'(pop);
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
        wr_ch  <= (wr_ch == TID_W'(NUM_CH - 1)) ? '0 : wr_ch + 1'b1;
      end
    end
  end

  // sdata is fed from the shifter's MSB one tick late, giving the one-bit data delay.
  always_ff @(posedge aud_mclk) begin
    if (!aud_mrst_n) begin
      state         <= IDLE;
      div_cnt       <= '0;
      bit_cnt       <= '0;
      slot_cnt      <= '0;
      shreg         <= '0;
      muted         <= 1'b0;
      underflow     <= 1'b0;
      i2s_sclk_out  <= 1'b0;
      i2s_lrclk_out <= 1'b0;
      i2s_sdata_out <= 1'b0;
    end else begin
      underflow <= 1'b0;
      if (state == IDLE) begin
        if (enable) begin
          state         <= RUN;
          div_cnt       <= '0;
          bit_cnt       <= '0;
          slot_cnt      <= '0;
          shreg         <= load_word;
          muted         <= !have_frame;
          underflow     <= !have_frame;
          i2s_sclk_out  <= 1'b0;
          i2s_lrclk_out <= (MODE == 1);
          i2s_sdata_out <= 1'b0;
        end
      end else begin
        div_cnt <= div_wrap ? '0 : div_cnt + 1'b1;
        if (div_wrap) i2s_sclk_out <= !i2s_sclk_out;
        if (fall_tick) begin
          if (frame_end && !enable) begin
            state         <= IDLE;
            div_cnt       <= '0;
            bit_cnt       <= '0;
            slot_cnt      <= '0;
            shreg         <= '0;
            muted         <= 1'b0;
            i2s_sclk_out  <= 1'b0;
            i2s_lrclk_out <= 1'b0;
            i2s_sdata_out <= 1'b0;
          end else begin
            bit_cnt       <= next_bit;
            slot_cnt      <= next_slot;
            i2s_lrclk_out <= next_lr;
            i2s_sdata_out <= shreg[SLOT_W-1];
            shreg         <= last_bit ? load_word : (shreg << 1);
            if (frame_end) begin
              muted     <= !have_frame;
              underflow <= !have_frame;
            end
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_i2s_tdm_tx_core.sv
// Directed bench: an I2S instance (2 ch, SCLK_DIV=1) and a TDM instance (8 ch, SCLK_DIV=2)
// share clock and reset; expected waveforms are built from hand-derived rules.
module tb_i2s_tdm_tx_core;
  logic clk = 1'b0;
  logic rst_n;
  logic i2s_en, tdm_en;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  i2s_tdm_tx_core_if #(.TDATA_W(32), .TID_W(3)) i2s_bus ();
  i2s_tdm_tx_core_if #(.TDATA_W(32), .TID_W(3)) tdm_bus ();

  logic       i2s_sclk, i2s_lr, i2s_sd, i2s_uf, i2s_terr;
  logic       tdm_sclk, tdm_fs, tdm_sd, tdm_uf, tdm_terr;
  logic [4:0] i2s_cnt, tdm_cnt;

  i2s_tdm_tx_core #(
    .AUD_WIDTH(24), .SLOT_W(32), .NUM_CH(2), .MODE(0), .SCLK_DIV(1),
    .FIFO_DEPTH(16), .TDATA_W(32), .TID_W(3)
  ) dut_i2s (
    .aud_mclk(clk), .aud_mrst_n(rst_n), .enable(i2s_en), .s_axis_aud(i2s_bus),
    .i2s_sclk_out(i2s_sclk), .i2s_lrclk_out(i2s_lr), .i2s_sdata_out(i2s_sd),
    .fifo_count(i2s_cnt), .underflow(i2s_uf), .tid_err(i2s_terr)
  );

  i2s_tdm_tx_core #(
    .AUD_WIDTH(24), .SLOT_W(32), .NUM_CH(8), .MODE(1), .SCLK_DIV(2),
    .FIFO_DEPTH(16), .TDATA_W(32), .TID_W(3)
  ) dut_tdm (
    .aud_mclk(clk), .aud_mrst_n(rst_n), .enable(tdm_en), .s_axis_aud(tdm_bus),
    .i2s_sclk_out(tdm_sclk), .i2s_lrclk_out(tdm_fs), .i2s_sdata_out(tdm_sd),
    .fifo_count(tdm_cnt), .underflow(tdm_uf), .tid_err(tdm_terr)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle;
    i2s_en = 1'b0;  tdm_en = 1'b0;
    i2s_bus.tvalid = 1'b0; i2s_bus.tid = '0; i2s_bus.tdata = '0;
    tdm_bus.tvalid = 1'b0; tdm_bus.tid = '0; tdm_bus.tdata = '0;
  endtask

  task automatic do_reset;
    drive_idle();
    rst_n = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic push_i2s(input logic [2:0] id, input logic [23:0] s);
    i2s_bus.tvalid = 1'b1; i2s_bus.tid = id; i2s_bus.tdata = {4'h0, s, 4'h0};
    tick();
    i2s_bus.tvalid = 1'b0;
  endtask

  task automatic push_tdm(input logic [2:0] id, input logic [23:0] s);
    tdm_bus.tvalid = 1'b1; tdm_bus.tid = id; tdm_bus.tdata = {4'h0, s, 4'h0};
    tick();
    tdm_bus.tvalid = 1'b0;
  endtask

  task automatic test_reset;
    drive_idle();
    rst_n = 1'b0;
    tick(); tick();
    n_checks++;
    if ({i2s_sclk, i2s_lr, i2s_sd, i2s_uf, i2s_terr, i2s_bus.tready} !== 6'b000001) begin
      n_fail++;
      $display("FAIL reset_i2s_outputs: got %b expected 000001",
               {i2s_sclk, i2s_lr, i2s_sd, i2s_uf, i2s_terr, i2s_bus.tready});
    end
    n_checks++;
    if ({tdm_sclk, tdm_fs, tdm_sd, tdm_uf, tdm_terr, tdm_bus.tready} !== 6'b000001) begin
      n_fail++;
      $display("FAIL reset_tdm_outputs: got %b expected 000001",
               {tdm_sclk, tdm_fs, tdm_sd, tdm_uf, tdm_terr, tdm_bus.tready});
    end
    n_checks++;
    if ({i2s_cnt, tdm_cnt} !== 10'd0) begin
      n_fail++;
      $display("FAIL reset_counts: got %0d/%0d expected 0/0", i2s_cnt, tdm_cnt);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_i2s_frame;
    logic [127:0] sclk_v, lr_v, sd_v, sclk_e, lr_e, sd_e;
    logic [23:0]  smp;
    logic         uf_seen, out_seen;
    do_reset();
    push_i2s(3'd0, 24'hA5A5A5);
    push_i2s(3'd1, 24'h5A5A5A);
    n_checks++;
    if (i2s_cnt !== 5'd2) begin
      n_fail++; $display("FAIL i2s_count_loaded: got %0d expected 2", i2s_cnt);
    end
    for (int k = 0; k < 128; k++) begin
      int p, b, s;
      p = k / 2; b = p % 32; s = p / 32;
      smp = (s == 0) ? 24'hA5A5A5 : 24'h5A5A5A;
      sclk_e[k] = (k % 2) == 1;
      lr_e[k]   = (s == 1);
      sd_e[k]   = (b >= 1 && b <= 24) ? smp[24-b] : 1'b0;
    end
    uf_seen = 1'b0;
    i2s_en  = 1'b1;
    tick();
    for (int k = 0; k < 128; k++) begin
      sclk_v[k] = i2s_sclk; lr_v[k] = i2s_lr; sd_v[k] = i2s_sd;
      uf_seen |= i2s_uf;
      if (k == 0 || k == 63 || k == 64) begin
        n_checks++;
        if (i2s_cnt !== ((k == 64) ? 5'd0 : 5'd1)) begin
          n_fail++;
          $display("FAIL i2s_count_cycle%0d: got %0d expected %0d", k, i2s_cnt, (k == 64) ? 0 : 1);
        end
      end
      if (k == 100) i2s_en = 1'b0;
      tick();
    end
    n_checks++;
    if (sclk_v !== sclk_e) begin
      n_fail++; $display("FAIL i2s_sclk: got %h expected %h", sclk_v, sclk_e);
    end
    n_checks++;
    if (lr_v !== lr_e) begin
      n_fail++; $display("FAIL i2s_lrclk: got %h expected %h", lr_v, lr_e);
    end
    n_checks++;
    if (sd_v !== sd_e) begin
      n_fail++; $display("FAIL i2s_sdata: got %h expected %h", sd_v, sd_e);
    end
    n_checks++;
    if (uf_seen !== 1'b0) begin
      n_fail++; $display("FAIL i2s_no_underflow: got %b expected 0", uf_seen);
    end
    out_seen = 1'b0;
    for (int k = 0; k < 20; k++) begin
      out_seen |= i2s_sclk | i2s_lr | i2s_sd;
      tick();
    end
    n_checks++;
    if (out_seen !== 1'b0) begin
      n_fail++; $display("FAIL i2s_disabled_idle: got %b expected 0", out_seen);
    end
  endtask

  task automatic test_underflow_and_reset;
    logic [199:0] sd_v, uf_v, lr_v, uf_e, lr_e;
    logic         cnt_moved;
    do_reset();
    push_i2s(3'd0, 24'h123456);
    n_checks++;
    if (i2s_cnt !== 5'd1) begin
      n_fail++; $display("FAIL uf_count_loaded: got %0d expected 1", i2s_cnt);
    end
    for (int k = 0; k < 200; k++) begin
      uf_e[k] = (k == 0) || (k == 128);
      lr_e[k] = (k % 128) >= 64;
    end
    cnt_moved = 1'b0;
    i2s_en = 1'b1;
    tick();
    for (int k = 0; k < 200; k++) begin
      sd_v[k] = i2s_sd; uf_v[k] = i2s_uf; lr_v[k] = i2s_lr;
      cnt_moved |= (i2s_cnt !== 5'd1);
      if (k == 199) rst_n = 1'b0;
      tick();
    end
    n_checks++;
    if ({i2s_sclk, i2s_lr, i2s_sd, i2s_uf, i2s_terr, i2s_bus.tready, i2s_cnt} !== {6'b000001, 5'd0}) begin
      n_fail++;
      $display("FAIL midframe_reset: got %b/%0d expected 000001/0",
               {i2s_sclk, i2s_lr, i2s_sd, i2s_uf, i2s_terr, i2s_bus.tready}, i2s_cnt);
    end
    i2s_en = 1'b0;
    rst_n  = 1'b1;
    tick();
    n_checks++;
    if (sd_v !== '0) begin
      n_fail++; $display("FAIL uf_muted_sdata: got %h expected 0", sd_v);
    end
    n_checks++;
    if (uf_v !== uf_e) begin
      n_fail++; $display("FAIL uf_pulses: got %h expected %h", uf_v, uf_e);
    end
    n_checks++;
    if (lr_v !== lr_e) begin
      n_fail++; $display("FAIL uf_lrclk: got %h expected %h", lr_v, lr_e);
    end
    n_checks++;
    if (cnt_moved !== 1'b0) begin
      n_fail++; $display("FAIL uf_count_held: got moved=%b expected 0", cnt_moved);
    end
  endtask

  task automatic test_tid_error;
    do_reset();
    push_i2s(3'd1, 24'h111111);
    n_checks++;
    if ({i2s_terr, i2s_cnt} !== {1'b1, 5'd0}) begin
      n_fail++; $display("FAIL tid_drop: got err=%b cnt=%0d expected err=1 cnt=0", i2s_terr, i2s_cnt);
    end
    tick();
    n_checks++;
    if (i2s_terr !== 1'b0) begin
      n_fail++; $display("FAIL tid_err_width: got %b expected 0", i2s_terr);
    end
    push_i2s(3'd0, 24'h222222);
    n_checks++;
    if ({i2s_terr, i2s_cnt} !== {1'b0, 5'd1}) begin
      n_fail++; $display("FAIL tid0_accept: got err=%b cnt=%0d expected err=0 cnt=1", i2s_terr, i2s_cnt);
    end
    push_i2s(3'd0, 24'h333333);
    n_checks++;
    if ({i2s_terr, i2s_cnt} !== {1'b1, 5'd1}) begin
      n_fail++; $display("FAIL tid_repeat_drop: got err=%b cnt=%0d expected err=1 cnt=1", i2s_terr, i2s_cnt);
    end
    push_i2s(3'd1, 24'h444444);
    n_checks++;
    if ({i2s_terr, i2s_cnt} !== {1'b0, 5'd2}) begin
      n_fail++; $display("FAIL tid1_accept: got err=%b cnt=%0d expected err=0 cnt=2", i2s_terr, i2s_cnt);
    end
  endtask

  task automatic test_full;
    int wait_cyc;
    do_reset();
    for (int i = 0; i < 16; i++) push_i2s(3'(i % 2), 24'h100000 + 24'(i));
    n_checks++;
    if ({i2s_cnt, i2s_bus.tready} !== {5'd16, 1'b0}) begin
      n_fail++; $display("FAIL full_level: got cnt=%0d tready=%b expected 16/0", i2s_cnt, i2s_bus.tready);
    end
    i2s_bus.tvalid = 1'b1; i2s_bus.tid = 3'd0; i2s_bus.tdata = {4'h0, 24'hBEEF00, 4'h0};
    repeat (3) tick();
    n_checks++;
    if (i2s_cnt !== 5'd16) begin
      n_fail++; $display("FAIL full_hold: got %0d expected 16", i2s_cnt);
    end
    i2s_en = 1'b1;
    tick();
    wait_cyc = -1;
    for (int w = 0; w < 50; w++) begin
      if (i2s_bus.tready) begin
        wait_cyc = w;
        break;
      end
      tick();
    end
    tick();
    i2s_bus.tvalid = 1'b0;
    n_checks++;
    if (wait_cyc !== 0) begin
      n_fail++; $display("FAIL full_tready_after_pop: got wait=%0d expected 0", wait_cyc);
    end
    n_checks++;
    if (i2s_cnt !== 5'd16) begin
      n_fail++; $display("FAIL full_refill: got %0d expected 16", i2s_cnt);
    end
    i2s_en = 1'b0;
    do_reset();
  endtask

  task automatic test_tdm_frame;
    logic [1023:0] sclk_v, fs_v, sd_v, sclk_e, fs_e, sd_e;
    do_reset();
    for (int c = 0; c < 8; c++) push_tdm(3'(c), 24'h800000 >> c);
    n_checks++;
    if (tdm_cnt !== 5'd8) begin
      n_fail++; $display("FAIL tdm_count_loaded: got %0d expected 8", tdm_cnt);
    end
    for (int k = 0; k < 1024; k++) begin
      int p;
      p = k / 4;
      sclk_e[k] = (k % 4) >= 2;
      fs_e[k]   = (p == 0);
      sd_e[k]   = ((p % 33) == 1) && (p / 33 < 8);
    end
    tdm_en = 1'b1;
    tick();
    for (int k = 0; k < 1024; k++) begin
      sclk_v[k] = tdm_sclk; fs_v[k] = tdm_fs; sd_v[k] = tdm_sd;
      if (k == 0 || k == 1023) begin
        n_checks++;
        if (tdm_cnt !== ((k == 0) ? 5'd7 : 5'd0)) begin
          n_fail++;
          $display("FAIL tdm_count_cycle%0d: got %0d expected %0d", k, tdm_cnt, (k == 0) ? 7 : 0);
        end
      end
      tick();
    end
    n_checks++;
    if (sclk_v !== sclk_e) begin
      n_fail++;
      for (int k = 0; k < 1024; k++) if (sclk_v[k] !== sclk_e[k]) begin
        $display("FAIL tdm_sclk: cycle %0d got %b expected %b", k, sclk_v[k], sclk_e[k]);
        break;
      end
    end
    n_checks++;
    if (fs_v !== fs_e) begin
      n_fail++;
      for (int k = 0; k < 1024; k++) if (fs_v[k] !== fs_e[k]) begin
        $display("FAIL tdm_fsync: cycle %0d got %b expected %b", k, fs_v[k], fs_e[k]);
        break;
      end
    end
    n_checks++;
    if (sd_v !== sd_e) begin
      n_fail++;
      for (int k = 0; k < 1024; k++) if (sd_v[k] !== sd_e[k]) begin
        $display("FAIL tdm_sdata: cycle %0d got %b expected %b", k, sd_v[k], sd_e[k]);
        break;
      end
    end
    n_checks++;
    if ({tdm_fs, tdm_uf, tdm_cnt} !== {2'b11, 5'd0}) begin
      n_fail++;
      $display("FAIL tdm_frame2_start: got fs=%b uf=%b cnt=%0d expected 1/1/0", tdm_fs, tdm_uf, tdm_cnt);
    end
    repeat (4) tick();
    n_checks++;
    if ({tdm_fs, tdm_uf} !== 2'b00) begin
      n_fail++; $display("FAIL tdm_fsync_width: got fs=%b uf=%b expected 0/0", tdm_fs, tdm_uf);
    end
    tdm_en = 1'b0;
    do_reset();
  endtask

  initial begin
    test_reset();
    test_i2s_frame();
    test_underflow_and_reset();
    test_tid_error();
    test_full();
    test_tdm_frame();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached, got no end expected end of test");
    $fatal(1, "bench time limit reached");
  end

endmodule
